// File: rtl/anubis_key_schedule.sv
// ANUBIS-128 key schedule: evolves the 4x4 key state once per round and presents
// round keys K0..K12 one at a time over a valid/ready handshake.
module anubis_key_schedule (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en,
  input  logic         start,
  input  logic [127:0] cipher_key,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] round_key,
  output logic [3:0]   rk_index,
  output logic         done
);

  // Byte x lives at bits [2047-8x -: 8].
  localparam logic [2047:0] SboxTab = {
    128'ha7d3e671_d0ac4d79_3ac991fc_1e4754bd, 128'h8ca57afb_63b8ddd4_e5b3c5be_a9880ca2,
    128'h39df29da_2ba8cb4c_4b22aa24_4170a6f9, 128'h5ae2b036_7de433ff_6020088b_5eab7f78,
    128'h7c2c57d2_dc6d7e0d_5394c328_27065fad, 128'h675c5548_0e52ea42_5b5d3058_51593c4e,
    128'h388a7214_e7c6de50_8e92d177_93459ace, 128'h2d0362b6_b9bf966b_3f0712ae_4034463e,
    128'hdbcfeccc_c1a1c0d6_1df4613b_10d868a0, 128'hb10a696c_49fa76c4_9e9b6e99_c2b798bc,
    128'h8f851fb4_f8112e00_251c2a3d_054f7bb2, 128'h3290af19_a3f7739d_1574eeca_9f0f1b75,
    128'h86849c4a_971a65f6_ed09bb26_83eb6f81, 128'h046a4301_17e187f5_8de32380_44166621,
    128'hfed531d9_35180264_f2f156cd_82c8baf0, 128'hefe9e8fd_89d7c7b5_a42f9513_0bf3e037
  };

  typedef enum logic [1:0] {StIdle, StGen, StHold, StFinish} state_e;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SboxTab[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1d : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) acc = acc ^ sh;
      sh = xtime(sh);
    end
    return acc;
  endfunction

  function automatic logic [7:0] gf_pow2(input int e);
    logic [7:0] p;
    p = 8'h01;
    for (int n = 0; n < 9; n++) begin
      if (n < e) p = xtime(p);
    end
    return p;
  endfunction

  function automatic logic [7:0] had(input int d);
    case (d & 3)
      0:       return 8'h01;
      1:       return 8'h02;
      2:       return 8'h04;
      default: return 8'h06;
    endcase
  endfunction

  function automatic logic [7:0] byte_at(input logic [127:0] v, input int n);
    return v[127-8*n -: 8];
  endfunction

  // Row-0 constant for c(idx+1), i.e. S-box bytes 4*idx .. 4*idx+3.
  function automatic logic [31:0] rc(input logic [3:0] idx);
    case (idx)
      4'd0:    return 32'ha7d3e671;
      4'd1:    return 32'hd0ac4d79;
      4'd2:    return 32'h3ac991fc;
      4'd3:    return 32'h1e4754bd;
      4'd4:    return 32'h8ca57afb;
      4'd5:    return 32'h63b8ddd4;
      4'd6:    return 32'he5b3c5be;
      4'd7:    return 32'ha9880ca2;
      4'd8:    return 32'h39df29da;
      4'd9:    return 32'h2ba8cb4c;
      4'd10:   return 32'h4b22aa24;
      4'd11:   return 32'h4170a6f9;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [127:0] gamma(input logic [127:0] a);
    logic [127:0] b;
    b = '0;
    for (int n = 0; n < 16; n++) b[127-8*n -: 8] = sbox(byte_at(a, n));
    return b;
  endfunction

  function automatic logic [127:0] pi_perm(input logic [127:0] a);
    logic [127:0] b;
    b = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) b[127-8*(4*i+j) -: 8] = byte_at(a, 4*((i-j+4)%4)+j);
    end
    return b;
  endfunction

  function automatic logic [127:0] theta(input logic [127:0] a);
    logic [127:0] b;
    logic [7:0]   acc;
    b = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        acc = '0;
        for (int k = 0; k < 4; k++) acc = acc ^ gf_mul(byte_at(a, 4*i+k), had(k ^ j));
        b[127-8*(4*i+j) -: 8] = acc;
      end
    end
    return b;
  endfunction

  // Multiply by the transposed Vandermonde matrix V[k][i] = 2^(k*i).
  function automatic logic [127:0] omega(input logic [127:0] a);
    logic [127:0] b;
    logic [7:0]   acc;
    b = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        acc = '0;
        for (int k = 0; k < 4; k++) acc = acc ^ gf_mul(gf_pow2(k*i), byte_at(a, 4*k+j));
        b[127-8*(4*i+j) -: 8] = acc;
      end
    end
    return b;
  endfunction

  state_e       state_q, state_d;
  logic [127:0] kappa_q, kappa_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   r_q, r_d;
  logic [3:0]   idx_q, idx_d;
  logic         busy_q, busy_d;
  logic         valid_q, valid_d;
  logic         done_q, done_d;
  logic [127:0] gamma_out;
  logic [127:0] rk_next;
  logic [127:0] kappa_next;

  // A single gamma feeds both the extracted key and the evolved state.
  assign gamma_out  = gamma(kappa_q);
  assign rk_next    = omega(gamma_out);
  assign kappa_next = theta(pi_perm(gamma_out)) ^ {rc(r_q), 96'h0};

  always_comb begin
    state_d = state_q;
    kappa_d = kappa_q;
    rk_d    = rk_q;
    r_d     = r_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        // The done cycle is still in IDLE; a start seen alongside it is dropped.
        if (start && !done_q) begin
          kappa_d = cipher_key;
          r_d     = 4'd0;
          busy_d  = 1'b1;
          state_d = StGen;
        end
      end
      StGen: begin
        rk_d    = rk_next;
        idx_d   = r_q;
        valid_d = 1'b1;
        if (r_q != 4'd12) kappa_d = kappa_next;
        state_d = StHold;
      end
      StHold: begin
        if (rk_ready) begin
          valid_d = 1'b0;
          if (idx_q < 4'd12) begin
            r_d     = r_q + 4'd1;
            state_d = StGen;
          end else begin
            state_d = StFinish;
          end
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      kappa_q <= '0;
      rk_q    <= '0;
      r_q     <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (clk_en) begin
      state_q <= state_d;
      kappa_q <= kappa_d;
      rk_q    <= rk_d;
      r_q     <= r_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign rk_valid  = valid_q;
  assign round_key = rk_q;
  assign rk_index  = idx_q;
  assign done      = done_q;

endmodule

// File: tb/tb_anubis_key_schedule.sv
// Randomised bench for anubis_key_schedule: a matrix-level ANUBIS model fills a
// scoreboard queue, and a monitor pops it on every completed handshake.
module tb_anubis_key_schedule;

  logic         clk = 1'b0;
  logic         rst, clk_en, start, rk_ready;
  logic         busy, rk_valid, done;
  logic [127:0] cipher_key, round_key;
  logic [3:0]   rk_index;

  int total = 0;
  int bad = 0;
  int done_pulses = 0;
  int en_mode = 0;
  int rdy_mode = 0;

  typedef struct {
    logic [127:0] key;
    logic [3:0]   idx;
  } exp_t;
  exp_t exp_q [$];

  logic [7:0] sb [256];
  localparam logic [2047:0] SboxBits = {
    128'ha7d3e671_d0ac4d79_3ac991fc_1e4754bd, 128'h8ca57afb_63b8ddd4_e5b3c5be_a9880ca2,
    128'h39df29da_2ba8cb4c_4b22aa24_4170a6f9, 128'h5ae2b036_7de433ff_6020088b_5eab7f78,
    128'h7c2c57d2_dc6d7e0d_5394c328_27065fad, 128'h675c5548_0e52ea42_5b5d3058_51593c4e,
    128'h388a7214_e7c6de50_8e92d177_93459ace, 128'h2d0362b6_b9bf966b_3f0712ae_4034463e,
    128'hdbcfeccc_c1a1c0d6_1df4613b_10d868a0, 128'hb10a696c_49fa76c4_9e9b6e99_c2b798bc,
    128'h8f851fb4_f8112e00_251c2a3d_054f7bb2, 128'h3290af19_a3f7739d_1574eeca_9f0f1b75,
    128'h86849c4a_971a65f6_ed09bb26_83eb6f81, 128'h046a4301_17e187f5_8de32380_44166621,
    128'hfed531d9_35180264_f2f156cd_82c8baf0, 128'hefe9e8fd_89d7c7b5_a42f9513_0bf3e037
  };

  anubis_key_schedule dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .start      (start),
    .cipher_key (cipher_key),
    .busy       (busy),
    .rk_valid   (rk_valid),
    .rk_ready   (rk_ready),
    .round_key  (round_key),
    .rk_index   (rk_index),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Carry-less product followed by reduction modulo x^8+x^4+x^3+x^2+1.
  function automatic int gmul(input int a, input int b);
    int p;
    p = 0;
    for (int n = 0; n < 8; n++) if (((b >> n) & 1) != 0) p = p ^ (a << n);
    for (int n = 14; n >= 8; n--) if (((p >> n) & 1) != 0) p = p ^ ('h11d << (n - 8));
    return p;
  endfunction

  function automatic int gpow2(input int e);
    int p;
    p = 1;
    for (int n = 0; n < e; n++) p = gmul(p, 2);
    return p;
  endfunction

  task automatic gen_expected(input logic [127:0] key);
    int   ka [4][4];
    int   g  [4][4];
    int   t  [4][4];
    int   hd [4];
    int   acc;
    exp_t e;
    hd = '{1, 2, 4, 6};
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) ka[i][j] = int'(key[127-8*(4*i+j) -: 8]);
    for (int r = 0; r <= 12; r++) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) g[i][j] = int'(sb[ka[i][j]]);
      e.key = '0;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          acc = 0;
          for (int k = 0; k < 4; k++) acc = acc ^ gmul(gpow2(k * i), g[k][j]);
          e.key[127-8*(4*i+j) -: 8] = 8'(acc);
        end
      e.idx = 4'(r);
      exp_q.push_back(e);
      // Next state: column-shift, Hadamard mix, then round constant into row 0.
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          acc = 0;
          for (int k = 0; k < 4; k++) acc = acc ^ gmul(g[(i - k + 4) % 4][k], hd[k ^ j]);
          t[i][j] = acc;
        end
      ka = t;
      if (r < 12) for (int j = 0; j < 4; j++) ka[0][j] = ka[0][j] ^ int'(sb[4 * r + j]);
    end
  endtask

  // Handshake partner and clock-enable pattern, updated just after each edge.
  initial begin
    int cyc;
    cyc = 0;
    clk_en = 1'b1;
    rk_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (en_mode)
        0:       clk_en = 1'b1;
        1:       clk_en = (cyc % 3 == 0);
        default: clk_en = 1'($urandom_range(0, 1));
      endcase
      rk_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pops the scoreboard on each handshake, checks holds and done timing.
  initial begin
    bit           held, watching, prev_done;
    logic [127:0] held_key;
    logic [3:0]   held_idx;
    int           en_count;
    exp_t         e;
    held = 0; watching = 0; prev_done = 0; en_count = 0;
    held_key = '0; held_idx = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 0; watching = 0; prev_done = 0;
        continue;
      end
      if (held) begin
        chk("hold valid", rk_valid, 1'b1);
        chk("hold key", round_key, held_key);
        chk("hold index", rk_index, held_idx);
      end
      held     = rk_valid && !(clk_en && rk_ready);
      held_key = round_key;
      held_idx = rk_index;
      if (done && !prev_done) begin
        done_pulses++;
        chk("done expected", watching, 1'b1);
        chk("done latency", en_count, 1);
        chk("busy at done", busy, 1'b0);
        watching = 0;
      end
      prev_done = done;
      if (watching && clk_en) en_count++;
      if (rk_valid && rk_ready && clk_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected key index", rk_index, 4'hf);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("round key %0d", e.idx), round_key, e.key);
          chk("key index", rk_index, e.idx);
          if (e.idx == 4'd12) begin
            watching = 1;
            en_count = 0;
          end
        end
      end
    end
  end

  task automatic run_key(input logic [127:0] key, input bit hold_start);
    int n;
    int base;
    gen_expected(key);
    base = done_pulses;
    start = 1'b1;
    cipher_key = key;
    n = 0;
    while (!busy && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("start accepted", busy, 1'b1);
    if (hold_start) cipher_key = ~key;
    else start = 1'b0;
    n = 0;
    while (done_pulses == base && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    if (hold_start) begin
      n = 0;
      while (done && n < 200) begin
        @(posedge clk); #1; n++;
      end
      start = 1'b0;
    end
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("done count", done_pulses - base, 1);
    chk("keys left", exp_q.size(), 0);
    chk("busy after finish", busy, 1'b0);
    chk("valid after finish", rk_valid, 1'b0);
  endtask

  initial begin
    int   n;
    logic any;
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic any;
    logic [127:0] rkey;
    for (int i = 0; i < 256; i++) sb[i] = SboxBits[2047-8*i -: 8];
    rst = 1'b1; start = 1'b0; cipher_key = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy, 1'b0);
    chk("reset valid", rk_valid, 1'b0);
    chk("reset key", round_key, '0);
    chk("reset index", rk_index, '0);
    chk("reset done", done, 1'b0);
    rst = 1'b0;

    en_mode = 0; rdy_mode = 0; run_key('0, 0);
    rdy_mode = 1; run_key(128'h000102030405060708090a0b0c0d0e0f, 0);
    en_mode = 1; rdy_mode = 0; run_key('0, 0);
    en_mode = 0; rdy_mode = 0; run_key({128{1'b1}}, 0);
    en_mode = 2; rdy_mode = 1;
    repeat (2) run_key({$urandom, $urandom, $urandom, $urandom}, 0);
    en_mode = 0; rdy_mode = 1;
    run_key(128'h0123456789abcdeffedcba9876543210, 1);

    // Asynchronous abort while K5 is on the bus, then a clean restart.
    en_mode = 0; rdy_mode = 0;
    rkey = {$urandom, $urandom, $urandom, $urandom};
    gen_expected(rkey);
    start = 1'b1; cipher_key = rkey;
    n = 0;
    while (!busy && n < 200) begin
      @(posedge clk); #1; n++;
    end
    start = 1'b0;
    n = 0;
    while (!(rk_valid && rk_index == 4'd5) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    chk("reached index 5", rk_index, 4'd5);
    #2 rst = 1'b1;
    #1;
    chk("abort busy", busy, 1'b0);
    chk("abort valid", rk_valid, 1'b0);
    chk("abort key", round_key, '0);
    chk("abort index", rk_index, '0);
    chk("abort done", done, 1'b0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    any = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      any = any | rk_valid | done | busy;
    end
    chk("quiet after abort", any, 1'b0);
    run_key(rkey, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/anubis_key_schedule.md
ANUBIS_KEY_SCHEDULE -- requirements
Module: anubis_key_schedule

Interface
REQ-001 The block SHALL have no parameters; it SHALL implement ANUBIS-128 only (N=4 key words, R=12 rounds, round keys K0..K12).
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 rst  in  1  asynchronous reset, active-high.
REQ-004 clk_en  in  1  clock enable; all state SHALL advance only on clk edges where clk_en=1.
REQ-005 start  in  1  load request; sampled only in IDLE.
REQ-006 cipher_key  in  128  key, byte b(4i+j) = cipher_key[127-8(4i+j) -: 8] = kappa[i][j].
REQ-007 busy  out  1  high from accepted start until done.
REQ-008 rk_valid  out  1  round_key and rk_index valid.
REQ-009 rk_ready  in  1  downstream round stage accepts the key.
REQ-010 round_key  out  128  current round key Kr, same byte order as cipher_key.
REQ-011 rk_index  out  4  r of the presented key, 0..12.
REQ-012 done  out  1  one-enabled-cycle pulse after K12 is accepted.

Function
REQ-013 The FSM SHALL have states IDLE, GEN, HOLD, FINISH.
REQ-014 In IDLE with clk_en=1 and start=1: kappa <= cipher_key, r <= 0, busy <= 1, next GEN; start in any other state SHALL be ignored.
REQ-015 GEN, clk_en=1: round_key <= omega(gamma(kappa)), rk_index <= r, rk_valid <= 1, kappa <= sigma[c(r+1)](theta(pi(gamma(kappa)))), next HOLD.
REQ-016 gamma SHALL apply the 256-entry ANUBIS S-box to all 16 bytes; one gamma instance SHALL feed both extraction and evolution.
REQ-017 pi SHALL map b[i][j] = a[(i-j) mod 4][j].
REQ-018 theta SHALL multiply by had(0x01,0x02,0x04,0x06) over GF(2^8), reduction polynomial 0x11D.
REQ-019 sigma[c(r)] SHALL XOR row 0 with S[4(r-1)+j] for j=0..3, other rows unchanged; constants SHALL be a 12x32-bit table, not extra S-box instances.
REQ-020 omega SHALL compute K[i][j] = XOR over k of V[k][i]*g[k][j], V[k][i] = (0x02)^(k*i) in GF(2^8).
REQ-021 HOLD: round_key, rk_index, rk_valid SHALL be stable while rk_ready=0 (no timeout).
REQ-022 HOLD with clk_en=1 and rk_ready=1: handshake completes; if rk_index<12 then r <= r+1, rk_valid <= 0, next GEN; if rk_index=12 then rk_valid <= 0, next FINISH.
REQ-023 Handshake latency SHALL be: key Kr presented 1 enabled cycle after entering GEN; next key presented 2 enabled cycles after the previous acceptance.
REQ-024 FINISH, clk_en=1: done <= 1 for one enabled cycle, busy <= 0, next IDLE; evolution result after K12 SHALL be discarded.
REQ-025 r SHALL never exceed 12; rk_index SHALL never wrap.
REQ-026 clk_en=0 SHALL freeze all registers and outputs, including a pending done pulse and rk_valid.
REQ-027 start asserted in the same cycle done is high SHALL be ignored; a new key SHALL only be accepted from IDLE.

Reset
REQ-028 On rst=1, regardless of clk or clk_en: state=IDLE, kappa=0, r=0, busy=0, rk_valid=0, rk_index=0, round_key=0, done=0.
REQ-029 Reset mid-generation SHALL abort immediately; no further rk_valid or done until a new start after reset release.
REQ-030 Outputs SHALL be registered; no combinational path from rk_ready or start to any output.

Verification
REQ-031 cipher_key=0, start pulse, rk_ready=1 constant -> 13 keys, rk_index 0..12, each matching the golden ANUBIS-128 model; done exactly once; busy low after FINISH.
REQ-032 cipher_key=0x000102...0F, rk_ready toggled randomly -> same 13 keys as rk_ready=1 run, in order, none skipped or duplicated; round_key stable while rk_ready=0.
REQ-033 clk_en=1 one cycle in three during the REQ-031 run -> identical key sequence; outputs unchanged on disabled cycles.
REQ-034 rst asserted while rk_index=5 is presented, asynchronously between edges -> all outputs 0 immediately; restart produces K0 again.
REQ-035 start held high during GEN/HOLD with a different cipher_key -> ignored; keys match the originally loaded key.
REQ-036 K0 check with cipher_key=all 0xFF -> round_key equals omega(gamma(key)) from the model; done rises exactly 1 enabled cycle after K12 acceptance.
